// File: rtl/tsqr_tile_streamer.sv
// Upstream feeder for tsqr_st512_1c: reads ug/pg tile rows from source memory and streams
// one row per cycle, pacing tiles beyond PRELOAD on the core's ping-pong buffer releases.
module tsqr_tile_streamer #(
    parameter int ROW_W        = 16384,
    parameter int MATRIX_WIDTH = 256,
    parameter int CNT_W        = 16,
    parameter int ADDR_W       = 16,
    parameter int PRELOAD      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  tile_no,
    output logic              src_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [ROW_W-1:0]  src_ug_dout,
    input  logic [ROW_W-1:0]  src_pg_dout,
    input  logic [95:0]       src_e_dout,
    output logic [ROW_W-1:0]  ug_i,
    output logic [ROW_W-1:0]  pg_i,
    output logic              ug_ready,
    output logic              pg_ready,
    output logic [31:0]       e_ug,
    output logic [31:0]       e_pg,
    output logic [31:0]       e_upg,
    output logic              e_ug_ready,
    output logic              e_pg_ready,
    output logic              e_upg_ready,
    input  logic              mem0_fi_c_0,
    input  logic              mem1_fi_c_0,
    output logic              busy,
    output logic              done
);
    localparam int ROW_CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WAIT_FI, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tile_no_q, tile_no_d;
    logic [CNT_W-1:0]  tile_q, tile_d;
    logic [ROW_CW-1:0] row_q, row_d;
    logic              fi0_q, fi0_d, fi1_q, fi1_d;
    logic              fi0_clr, fi1_clr;
    logic              done_q, done_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_tile0_q, s1_tile0_d;
    logic [ROW_W-1:0]  ug_q, ug_d, pg_q, pg_d;
    logic              rdy_q, rdy_d, e_rdy_q, e_rdy_d;
    logic [31:0]       eug_q, eug_d, epg_q, epg_d, eupg_q, eupg_d;

    logic [CNT_W-1:0]  next_tile, rel_tile;
    logic              last_row, last_tile, in_preload, need_fi1, need_hit;

    always_comb begin
        last_row   = (row_q == ROW_CW'(MATRIX_WIDTH - 1));
        last_tile  = (tile_q == tile_no_q - CNT_W'(1));
        next_tile  = (state_q == WAIT_FI) ? tile_q : tile_q + CNT_W'(1);
        in_preload = (32'(next_tile) < 32'(PRELOAD));
        // Buffer parity of the tile about to be read selects which release it needs.
        rel_tile   = next_tile - CNT_W'(PRELOAD);
        need_fi1   = rel_tile[0];
        need_hit   = need_fi1 ? fi1_q : fi0_q;
    end

    always_comb begin
        state_d   = state_q;
        tile_no_d = tile_no_q;
        tile_d    = tile_q;
        row_d     = row_q;
        done_d    = 1'b0;
        fi0_clr   = 1'b0;
        fi1_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (tile_no == '0) begin
                        done_d = 1'b1;
                    end else begin
                        tile_no_d = tile_no;
                        tile_d    = '0;
                        row_d     = '0;
                        fi0_clr   = 1'b1;
                        fi1_clr   = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            READ: begin
                if (last_row) begin
                    row_d  = '0;
                    tile_d = next_tile;
                    if (last_tile) begin
                        state_d = FLUSH;
                    end else if (!in_preload) begin
                        // A release that already arrived is consumed here, so no bubble.
                        if (need_hit) begin
                            fi0_clr = !need_fi1;
                            fi1_clr = need_fi1;
                        end else begin
                            state_d = WAIT_FI;
                        end
                    end
                end else begin
                    row_d = row_q + ROW_CW'(1);
                end
            end
            WAIT_FI: begin
                if (need_hit) begin
                    fi0_clr = !need_fi1;
                    fi1_clr = need_fi1;
                    state_d = READ;
                end
            end
            FLUSH: begin
                if (!s1_valid_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fi0_d = (fi0_q | (mem0_fi_c_0 && state_q != IDLE)) & ~fi0_clr;
        fi1_d = (fi1_q | (mem1_fi_c_0 && state_q != IDLE)) & ~fi1_clr;
    end

    always_comb begin
        s1_valid_d = (state_q == READ);
        s1_tile0_d = (state_q == READ) && (tile_q == '0);
        rdy_d      = s1_valid_q;
        e_rdy_d    = s1_valid_q && s1_tile0_q;
        ug_d       = ug_q;
        pg_d       = pg_q;
        eug_d      = eug_q;
        epg_d      = epg_q;
        eupg_d     = eupg_q;
        if (s1_valid_q) begin
            ug_d = src_ug_dout;
            pg_d = src_pg_dout;
        end
        if (e_rdy_d) begin
            eug_d  = src_e_dout[31:0];
            epg_d  = src_e_dout[63:32];
            eupg_d = src_e_dout[95:64];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_no_q  <= '0;
            tile_q     <= '0;
            row_q      <= '0;
            fi0_q      <= 1'b0;
            fi1_q      <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_tile0_q <= 1'b0;
            ug_q       <= '0;
            pg_q       <= '0;
            rdy_q      <= 1'b0;
            e_rdy_q    <= 1'b0;
            eug_q      <= '0;
            epg_q      <= '0;
            eupg_q     <= '0;
        end else begin
            state_q    <= state_d;
            tile_no_q  <= tile_no_d;
            tile_q     <= tile_d;
            row_q      <= row_d;
            fi0_q      <= fi0_d;
            fi1_q      <= fi1_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_tile0_q <= s1_tile0_d;
            ug_q       <= ug_d;
            pg_q       <= pg_d;
            rdy_q      <= rdy_d;
            e_rdy_q    <= e_rdy_d;
            eug_q      <= eug_d;
            epg_q      <= epg_d;
            eupg_q     <= eupg_d;
        end
    end

    assign src_en      = (state_q == READ);
    assign src_addr    = ADDR_W'(tile_q) * ADDR_W'(MATRIX_WIDTH) + ADDR_W'(row_q);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign ug_i        = ug_q;
    assign pg_i        = pg_q;
    assign ug_ready    = rdy_q;
    assign pg_ready    = rdy_q;
    assign e_ug        = eug_q;
    assign e_pg        = epg_q;
    assign e_upg       = eupg_q;
    assign e_ug_ready  = e_rdy_q;
    assign e_pg_ready  = e_rdy_q;
    assign e_upg_ready = e_rdy_q;

endmodule
